// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the slow-clock edge monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam int DEF_EXP_HALF = 50;
  localparam int DEF_TOL      = 2;
  localparam int DEF_LOCK_N   = 4;
  localparam int DEF_CNT_W    = 25;

endpackage

// File: rtl/clk_edge_monitor_sync_edge_det.sv
// Brings the asynchronous slow input into the clk domain and flags its level changes.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic any_edge,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 form the metastability filter; s3 is the one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign any_edge = s2 ^ s3;
  assign rise     = s2 & ~s3;

endmodule

// File: rtl/clk_edge_monitor.sv
// Measures each half-period of a slow square wave in clk cycles, emits ticks,
// and tracks frequency lock plus a sticky fault for off-frequency or stalled input.
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_HALF = DEF_EXP_HALF,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_N   = DEF_LOCK_N,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  input  logic             clr_fault,
  output logic             tick,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             lock,
  output logic             fault
);

  localparam int GW   = $clog2(LOCK_N + 1);
  localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam int HI_I = EXP_HALF + TOL;
  localparam int TO_I = HI_I + 1;

  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_I);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TO_I);

  if (longint'(TO_I) >= (longint'(1) << CNT_W)) begin : g_width_chk
    $error("clk_edge_monitor: EXP_HALF+TOL+1 does not fit in CNT_W bits");
  end
  if (LOCK_N < 1) begin : g_lock_chk
    $error("clk_edge_monitor: LOCK_N must be at least 1");
  end

  logic             s_edge;
  logic             s_rise;
  logic [CNT_W-1:0] cnt;
  logic             first_edge;
  logic             gap_timed;
  logic             in_range;
  logic             meas;
  logic             good_meas;
  logic             timeout;
  logic             bad;
  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    good;
  logic [GW-1:0]    good_nxt;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (slow_in),
    .any_edge (s_edge),
    .rise     (s_rise)
  );

  assign in_range  = (cnt >= LO_C) && (cnt <= HI_C);
  assign meas      = s_edge & ~first_edge;
  assign good_meas = meas & in_range;
  // gap_timed keeps a stuck counter (e.g. saturated at the timeout value) from re-firing.
  assign timeout   = ~first_edge & ~s_edge & ~gap_timed & (cnt == TO_C);
  assign bad       = (meas & ~in_range) | timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      first_edge  <= 1'b1;
      gap_timed   <= 1'b0;
      tick        <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
    end else begin
      tick       <= s_rise;
      meas_valid <= meas;
      if (meas) begin
        half_period <= cnt;
      end
      if (s_edge) begin
        cnt        <= CNT_W'(1);
        first_edge <= 1'b0;
        gap_timed  <= 1'b0;
      end else begin
        if (cnt != '1) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (timeout) begin
          gap_timed <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      good  <= '0;
      lock  <= 1'b0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
      lock  <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      UNLOCKED: begin
        if (good_meas) begin
          good_nxt  = GW'(1);
          state_nxt = (LOCK_N == 1) ? LOCKED : ACQUIRE;
        end else if (bad) begin
          good_nxt = '0;
        end
      end
      ACQUIRE: begin
        if (good_meas) begin
          good_nxt = good + GW'(1);
          if (good + GW'(1) == GW'(LOCK_N)) begin
            state_nxt = LOCKED;
          end
        end else if (bad) begin
          state_nxt = UNLOCKED;
          good_nxt  = '0;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_nxt = UNLOCKED;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = UNLOCKED;
        good_nxt  = '0;
      end
    endcase
  end

  // Set has priority so a fault arriving with a clear request is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (bad) begin
      fault <= 1'b1;
    end else if (clr_fault) begin
      fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Bench for clk_edge_monitor: drives timed half-periods and checks measurements, lock and fault.
`timescale 1ns/1ps
module tb_clk_edge_monitor;
  import clk_mon_pkg::*;

  localparam int CNT_W = DEF_CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             slow_in = 1'b0;
  logic             clr_fault = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             lock;
  logic             fault;

  int n_tests = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int rise_cnt = 0;
  int prev_k = 0;
  int frozen = 0;
  int found;
  logic lock_before;

  logic [CNT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  clk_edge_monitor #(
    .EXP_HALF (DEF_EXP_HALF),
    .TOL      (DEF_TOL),
    .LOCK_N   (DEF_LOCK_N),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slow_in     (slow_in),
    .clr_fault   (clr_fault),
    .tick        (tick),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .lock        (lock),
    .fault       (fault)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every edge of slow_in closes the previous half-period, whose length becomes the expected measurement.
  task automatic toggle_push();
    slow_in = ~slow_in;
    if (slow_in) rise_cnt++;
    if (prev_k != 0) exp_q.push_back(CNT_W'(prev_k));
  endtask

  task automatic hold(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic seg(input int k);
    toggle_push();
    prev_k = k;
    hold(k);
  endtask

  task automatic clr_pulse();
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit wiggle);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      check_val("rst_out", {tick, meas_valid, lock, fault, half_period}, 32'd0);
      if (wiggle) slow_in = ~slow_in;
      @(negedge clk);
    end
    check_val("rst_q_empty", exp_q.size(), 32'd0);
    slow_in = 1'b0;
    rst_n   = 1'b1;
    prev_k  = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tick) tick_cnt++;
        if (meas_valid) begin
          if (exp_q.size() == 0) check_val("meas_unexp", 32'd1, 32'd0);
          else check_val("half_period", half_period, exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fork
      monitor();
    join_none

    // 1: reset with a wiggling input
    do_reset(5, 1'b1);

    // 2: nominal 50-cycle half-periods
    for (int i = 0; i < 4; i++) seg(50);
    check_val("t2_lock_pre", lock, 1'b0);
    seg(50);
    check_val("t2_lock", lock, 1'b1);
    check_val("t2_fault", fault, 1'b0);

    // 3: tolerance edges keep lock; 53 breaks it
    seg(48); seg(52); seg(49); seg(51); seg(53);
    check_val("t3_lock_tol", lock, 1'b1);
    check_val("t3_fault_tol", fault, 1'b0);
    toggle_push();
    prev_k = 50;
    found = 0;
    lock_before = lock;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        found = i;
        break;
      end
      lock_before = lock;
    end
    check_val("t3_meas_seen", found != 0, 1'b1);
    check_val("t3_lock_before", lock_before, 1'b1);
    check_val("t3_lock_drop", lock, 1'b0);
    check_val("t3_fault_set", fault, 1'b1);
    hold(50 - found);

    // relock, clearing the sticky fault along the way
    for (int i = 0; i < 3; i++) seg(50);
    toggle_push();
    prev_k = 50;
    clr_pulse();
    check_val("t3_fault_clr", fault, 1'b0);
    hold(49);
    check_val("t3_relock", lock, 1'b1);

    // 4: frozen input -> single timeout when the count reaches 53
    toggle_push();
    found = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (fault) begin
        found = i;
        break;
      end
    end
    check_val("t4_timeout_cyc", found, 32'd56);
    check_val("t4_lock", lock, 1'b0);
    frozen = found;
    clr_pulse();
    frozen++;
    check_val("t4_fault_clr", fault, 1'b0);
    hold(100);
    frozen += 100;
    check_val("t4_once", fault, 1'b0);
    prev_k = frozen;
    seg(50);
    check_val("t4_resume_fault", fault, 1'b1);
    seg(50); seg(50); seg(50);
    check_val("t4_lock_pre", lock, 1'b0);
    seg(50);
    check_val("t4_relock", lock, 1'b1);

    // 5: clear request colliding with a new out-of-range edge
    toggle_push();
    prev_k = 45;
    clr_pulse();
    check_val("t5_fault_clr0", fault, 1'b0);
    hold(44);
    toggle_push();
    prev_k = 50;
    hold(2);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check_val("t5_set_wins", fault, 1'b1);
    check_val("t5_lock", lock, 1'b0);
    clr_pulse();
    check_val("t5_clr_alone", fault, 1'b0);
    hold(46);

    // 6: reset in the middle of acquisition
    seg(50); seg(50); seg(50);
    check_val("t6_lock_acq", lock, 1'b0);
    do_reset(5, 1'b0);
    for (int i = 0; i < 4; i++) seg(50);
    check_val("t6_lock_pre", lock, 1'b0);
    seg(50);
    check_val("t6_lock", lock, 1'b1);
    check_val("t6_fault", fault, 1'b0);

    // final report
    hold(5);
    check_val("q_left", exp_q.size(), 32'd0);
    check_val("tick_cnt", tick_cnt, rise_cnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
